// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg
// Shared widths, limits, set-FSM state type and the 24h -> 12h hour mapping
// used by the real-time-clock core and its counter sub-module.
// -----------------------------------------------------------------------------
package rtc_pkg;

   localparam int SEC_W   = 6;
   localparam int MIN_W   = 6;
   localparam int HR_W    = 5;

   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;
   localparam int HR_MAX  = 23;

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } set_state_t;

   // 0 -> 12, 1..12 unchanged, 13..23 -> hour-12
   function automatic logic [HR_W-1:0] hr_to_12h(input logic [HR_W-1:0] hr24);
      logic [HR_W-1:0] res;
      if (hr24 == '0)
         res = HR_W'(12);
      else if (hr24 > HR_W'(12))
         res = hr24 - HR_W'(12);
      else
         res = hr24;
      return res;
   endfunction

endpackage

// File: rtl/rtc_time_core_mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Modulo-(MAX+1) counter with synchronous load, used for seconds, minutes and
// hours of the real-time clock.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset, value -> 0
//   en       : advance by one (wraps MAX -> 0)
//   load     : load load_val (takes priority over en)
//   load_val : value to load
//   value    : current count
//   wrap     : en && value == MAX, i.e. this advance rolls over
// -----------------------------------------------------------------------------
module mod_counter #(
   parameter int W   = 6,
   parameter int MAX = 59
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         wrap
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   assign wrap = en && (value == MAX_V);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         value <= '0;
      else if (load)
         value <= load_val;
      else if (en)
         value <= wrap ? '0 : value + 1'b1;
   end

endmodule

// File: rtl/rtc_time_core.sv
// -----------------------------------------------------------------------------
// rtc_time_core
// Seconds/minutes/hours real-time clock with a clk prescaler, 12/24-hour hour
// display, a validated time-set handshake and per-unit rollover pulses.
// Optional alarm comparator is compiled in when RTC_ALARM_EN is defined.
//
// Parameters
//   TICK_DIV : clk cycles per second tick (>= 2)
//   PRE_W    : prescaler width, 2**PRE_W >= TICK_DIV
// Ports
//   clk, rst                  : clock (rising), async active-high reset
//   run                       : 1 = time advances, 0 = time/prescaler frozen
//   mode_12h                  : hr_out in 12-hour (1) or 24-hour (0) form
//   set_valid/set_ready       : time-set handshake
//   set_hr/set_min/set_sec    : time to load (24-hour form)
//   set_err                   : one-cycle pulse on a rejected set request
//   sec_out/min_out/hr_out/pm : current time
//   sec_tick/min_tick/hr_tick/day_tick : one-cycle rollover pulses
//   (RTC_ALARM_EN) alarm_wr, alarm_hr, alarm_min, alarm_on, alarm_hit
// -----------------------------------------------------------------------------
module rtc_time_core
   import rtc_pkg::*;
#(
   parameter int TICK_DIV = 100000000,
   parameter int PRE_W    = 27
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             mode_12h,
   input  logic             set_valid,
   output logic             set_ready,
   input  logic [HR_W-1:0]  set_hr,
   input  logic [MIN_W-1:0] set_min,
   input  logic [SEC_W-1:0] set_sec,
   output logic             set_err,
   output logic [SEC_W-1:0] sec_out,
   output logic [MIN_W-1:0] min_out,
   output logic [HR_W-1:0]  hr_out,
   output logic             pm,
   output logic             sec_tick,
   output logic             min_tick,
   output logic             hr_tick,
   output logic             day_tick
`ifdef RTC_ALARM_EN
   ,
   input  logic             alarm_wr,
   input  logic [HR_W-1:0]  alarm_hr,
   input  logic [MIN_W-1:0] alarm_min,
   input  logic             alarm_on,
   output logic             alarm_hit
`endif
);

   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
   localparam logic [HR_W-1:0]  HR_MAX_V  = HR_W'(HR_MAX);
   localparam logic [MIN_W-1:0] MIN_MAX_V = MIN_W'(MIN_MAX);
   localparam logic [SEC_W-1:0] SEC_MAX_V = SEC_W'(SEC_MAX);

   set_state_t       state_reg;
   logic [PRE_W-1:0] pre_reg;
   logic [HR_W-1:0]  cap_hr_reg;
   logic [MIN_W-1:0] cap_min_reg;
   logic [SEC_W-1:0] cap_sec_reg;
   logic             set_ready_reg;
   logic             set_err_reg;
   logic             sec_tick_reg, min_tick_reg, hr_tick_reg, day_tick_reg;

   logic [SEC_W-1:0] sec_val;
   logic [MIN_W-1:0] min_val;
   logic [HR_W-1:0]  hr_val;
   logic             sec_wrap, min_wrap, hr_wrap;

   logic in_range, handshake, accept, reject, pre_wrap, tick, load;

   assign in_range  = (set_hr <= HR_MAX_V) && (set_min <= MIN_MAX_V) && (set_sec <= SEC_MAX_V);
   assign handshake = set_valid && set_ready_reg;
   assign accept    = handshake && in_range;
   assign reject    = handshake && !in_range;
   assign pre_wrap  = run && (state_reg == IDLE) && (pre_reg == PRE_LAST);
   // An accepted set on the wrap cycle swallows that second's tick.
   assign tick      = pre_wrap && !accept;
   assign load      = (state_reg == LOAD);

   // Set FSM, prescaler and registered pulse flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         pre_reg       <= '0;
         cap_hr_reg    <= '0;
         cap_min_reg   <= '0;
         cap_sec_reg   <= '0;
         set_ready_reg <= 1'b1;
         set_err_reg   <= 1'b0;
         sec_tick_reg  <= 1'b0;
         min_tick_reg  <= 1'b0;
         hr_tick_reg   <= 1'b0;
         day_tick_reg  <= 1'b0;
      end else begin
         set_err_reg  <= reject;
         sec_tick_reg <= tick;
         min_tick_reg <= sec_wrap;
         hr_tick_reg  <= min_wrap;
         day_tick_reg <= hr_wrap;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  cap_hr_reg    <= set_hr;
                  cap_min_reg   <= set_min;
                  cap_sec_reg   <= set_sec;
                  state_reg     <= LOAD;
                  set_ready_reg <= 1'b0;
                  pre_reg       <= '0;
               end else if (run) begin
                  pre_reg <= pre_wrap ? '0 : pre_reg + 1'b1;
               end
            end
            LOAD: begin
               // Counters take the captured time this cycle; restart the second.
               pre_reg       <= '0;
               state_reg     <= IDLE;
               set_ready_reg <= 1'b1;
            end
            default: begin
               state_reg     <= IDLE;
               set_ready_reg <= 1'b1;
            end
         endcase
      end
   end

   mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
      .clk(clk), .rst(rst), .en(tick), .load(load),
      .load_val(cap_sec_reg), .value(sec_val), .wrap(sec_wrap)
   );

   mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
      .clk(clk), .rst(rst), .en(sec_wrap), .load(load),
      .load_val(cap_min_reg), .value(min_val), .wrap(min_wrap)
   );

   mod_counter #(.W(HR_W), .MAX(HR_MAX)) u_hr (
      .clk(clk), .rst(rst), .en(min_wrap), .load(load),
      .load_val(cap_hr_reg), .value(hr_val), .wrap(hr_wrap)
   );

   assign set_ready = set_ready_reg;
   assign set_err   = set_err_reg;
   assign sec_out   = sec_val;
   assign min_out   = min_val;
   assign hr_out    = mode_12h ? hr_to_12h(hr_val) : hr_val;
   assign pm        = (hr_val >= HR_W'(12));
   assign sec_tick  = sec_tick_reg;
   assign min_tick  = min_tick_reg;
   assign hr_tick   = hr_tick_reg;
   assign day_tick  = day_tick_reg;

`ifdef RTC_ALARM_EN
   logic [HR_W-1:0]  alarm_hr_reg;
   logic [MIN_W-1:0] alarm_min_reg;
   logic             alarm_hit_reg;
   logic [HR_W-1:0]  next_hr;
   logic [MIN_W-1:0] next_min;

   // Hour:minute the counters will hold after a seconds rollover.
   assign next_min = min_wrap ? '0 : min_val + 1'b1;
   assign next_hr  = hr_wrap ? '0 : (min_wrap ? hr_val + 1'b1 : hr_val);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alarm_hr_reg  <= '0;
         alarm_min_reg <= '0;
         alarm_hit_reg <= 1'b0;
      end else begin
         if (alarm_wr && (alarm_hr <= HR_MAX_V) && (alarm_min <= MIN_MAX_V)) begin
            alarm_hr_reg  <= alarm_hr;
            alarm_min_reg <= alarm_min;
         end
         // Only a counted rollover can fire; a load never produces sec_wrap.
         alarm_hit_reg <= sec_wrap && alarm_on &&
                          (next_hr == alarm_hr_reg) && (next_min == alarm_min_reg);
      end
   end

   assign alarm_hit = alarm_hit_reg;
`endif

endmodule

// File: doc/rtc_time_core.md
Name: rtc_time_core

Overview:
- Parametrised successor to the cascaded minute/hour counters: one block holds seconds, minutes and hours.
- Contents:
  - clock prescaler
  - 12/24-hour display mode
  - validated time-set handshake
  - per-unit rollover pulses
- Sits between the system clock and the display/BCD driver; replaces the chained min/hr instances.

Parameters:
- TICK_DIV, 100000000: clk cycles per second tick; must be >= 2.
- PRE_W, 27: prescaler width; must satisfy 2**PRE_W >= TICK_DIV.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  1 = time advances; 0 = time and prescaler frozen
- mode_12h  in  1  1 = hr_out in 12-hour form; 0 = 24-hour form
- set_valid  in  1  time-set request
- set_ready  out  1  block can accept a set request
- set_hr  in  5  hour to load, 24-hour form (0-23)
- set_min  in  6  minute to load (0-59)
- set_sec  in  6  second to load (0-59)
- set_err  out  1  one-cycle pulse when a set request is rejected
- sec_out  out  6  seconds 0-59
- min_out  out  6  minutes 0-59
- hr_out  out  5  hours; 0-23 in 24-hour mode, 1-12 in 12-hour mode
- pm  out  1  1 when internal hour >= 12
- sec_tick  out  1  one-cycle pulse per second advance
- min_tick  out  1  one-cycle pulse when seconds wrap 59->0
- hr_tick  out  1  one-cycle pulse when minutes wrap 59->0
- day_tick  out  1  one-cycle pulse when hours wrap 23->0

Behaviour:
- Reset: asynchronous, active-high; all registers clear.
  - Time reads 00:00:00; prescaler 0.
  - All ticks and set_err 0; set_ready 1; FSM in IDLE.
- Time is stored internally in 24-hour form. mode_12h affects only hr_out; it is combinational from the internal hour.
  - 12-hour mapping: 0->12, 1..12 unchanged, 13..23 -> hour-12.
  - pm is independent of mode.
- Prescaler:
  - When run=1 and the FSM is in IDLE, it counts 0..TICK_DIV-1.
  - At TICK_DIV-1 it wraps to 0 and raises an internal tick for that cycle.
- Tick cascade: on the tick, sec increments. All updates are registered in the same cycle, so counters and pulses change on the same edge.
  - sec 59->0 advances min.
  - min 59->0 advances hr.
  - hr 23->0 asserts day_tick.
- Tick pulse flags are registered alongside the counters and are high for exactly one cycle.
  - 23:59:59 + tick -> 00:00:00 with sec_tick, min_tick, hr_tick and day_tick all high together.
- run=0: prescaler and counters hold; no ticks are generated. The set handshake is still serviced.
- Set FSM, states IDLE and LOAD:
  - IDLE: set_ready=1. A handshake occurs when set_valid=1 and set_ready=1.
    - Range check: set_hr<=23, set_min<=59, set_sec<=59.
    - Valid -> go to LOAD.
    - Invalid -> set_err=1 on the next cycle, stay in IDLE, time unchanged.
  - LOAD: set_ready=0 for exactly one cycle.
    - Load the values captured at the handshake into the counters.
    - Clear the prescaler; no tick pulses are issued.
    - Return to IDLE.
  - Loaded time is visible on outputs 2 cycles after the handshake edge.
  - The first tick after a load comes TICK_DIV cycles after returning to IDLE.
- Simultaneous handshake and prescaler wrap: the set wins. The tick and its pulses are discarded and the prescaler clears.
- set_valid while in LOAD is ignored; the requester must hold it until set_ready.
- Reset asserted in LOAD aborts the load; time is 00:00:00.

Optional Feature:
- Macro: RTC_ALARM_EN.
- When defined, extra ports are added:
  - alarm_wr in 1
  - alarm_hr in 5
  - alarm_min in 6
  - alarm_on in 1
  - alarm_hit out 1
- alarm_wr=1 captures alarm_hr/alarm_min, provided alarm_hr<=23 and alarm_min<=59; out-of-range writes are ignored. Reset value is 00:00.
- alarm_hit pulses for one cycle on the min_tick edge when:
  - alarm_on=1, and
  - the new hour:minute equals the alarm with sec=0.
- A load that lands exactly on the alarm time does not fire alarm_hit.
- When not defined: the ports are absent, there is no alarm logic, and all other behaviour is identical.

Decomposition:
- Package rtc_pkg holds:
  - widths SEC_W=6, MIN_W=6, HR_W=5
  - constants SEC_MAX=59, MIN_MAX=59, HR_MAX=23
  - FSM state enum {IDLE, LOAD}
- Sub-module mod_counter, parametrised by width and MAX, instanced three times for sec/min/hr. It has:
  - en, load and load_val inputs
  - value output
  - wrap output, asserted when en and value==MAX
- The prescaler, FSM and 12-hour mapping stay in rtc_time_core.

Test Plan:
1. TICK_DIV=4, rst pulse, run=1 for 16 cycles -> sec_tick every 4th cycle; sec_out=4; all other ticks 0.
2. Set 23:59:58 (valid), run=1 for 8 cycles -> time 00:00:00, and sec/min/hr/day_tick all high in one cycle.
3. Set 12:30:00, then 00:00:05, toggling mode_12h -> hr_out 12 / 12, pm 1 / 0 for 12-hour mode; 24-hour mode shows 12 and 0.
4. Set request with set_min=60 -> set_err high 1 cycle; set_ready stays 1; time unchanged.
5. set_valid timed on the prescaler wrap cycle -> no sec_tick; loaded time appears 2 cycles later; next sec_tick 4 cycles after return to IDLE.
6. RTC_ALARM_EN defined: alarm 07:00 with alarm_on=1, set 06:59:58 -> alarm_hit one cycle, coincident with min_tick at 07:00:00. Mid-run async rst -> all outputs 0 immediately.
